s2mm_ring_writer: RTL

Parametrised successor to the single-burst stream-to-memory writer. Buffers an AXI4-Stream in an inferred FIFO and emits full fixed-length AXI4 INCR write bursts into a run-time-configured circular DDR region, wrapping at the region end. Tracks outstanding write responses, reports the write pointer for software polling, and flags response errors and overflow. Sits between the acquisition pipeline and the PS HP port.

---
 rtl/s2mm_ring_writer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/s2mm_ring_writer.sv
// s2mm_ring_writer: AXI4-Stream -> FWFT FIFO -> fixed-length AXI4 INCR bursts into a DDR ring.
// Optional build macro S2MM_DROP_ON_FULL_EN: discard beats while full and count them in drop_count.
module s2mm_ring_writer #(
   parameter int ADDR_WIDTH      = 32,
   parameter int AXI_ID_WIDTH    = 6,
   parameter int DATA_WIDTH      = 64,
   parameter int BURST_LEN       = 16,
   parameter int FIFO_DEPTH      = 64,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic                      enable,
   input  logic [ADDR_WIDTH-1:0]     cfg_base,
   input  logic [ADDR_WIDTH-1:0]     cfg_size,
   output logic [ADDR_WIDTH-1:0]     wr_ptr,
   output logic [31:0]               bursts_done,
   output logic                      resp_err,
   output logic                      overflow,
`ifdef S2MM_DROP_ON_FULL_EN
   output logic [31:0]               drop_count,
`endif
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   output logic [AXI_ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [7:0]                m_axi_awlen,
   output logic [2:0]                m_axi_awsize,
   output logic [1:0]                m_axi_awburst,
   output logic [3:0]                m_axi_awcache,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wlast,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready
);

   localparam int LW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0] BYTES = (ADDR_WIDTH+1)'(BURST_LEN * DATA_WIDTH / 8);
   localparam logic [LW:0] LVL_FULL  = (LW+1)'(FIFO_DEPTH);
   localparam logic [LW:0] LVL_BURST = (LW+1)'(BURST_LEN);
   localparam logic [4:0]  BEAT_LAST = 5'(BURST_LEN - 1);
   localparam logic [3:0]  OUT_MAX   = 4'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [LW-1:0]         wa_q, ra_q;
   logic [LW:0]           level_q;
   logic                  full, push, pop;

   state_t                state_q;
   logic                  awvalid_q, wvalid_q, enable_q;
   logic [ADDR_WIDTH-1:0] awaddr_q, size_q, wr_ptr_q;
   logic [4:0]            beat_q;
   logic [3:0]            outst_q;
   logic [31:0]           bursts_q, drop_q;
   logic                  err_q, ovf_q;

   logic [ADDR_WIDTH:0]   ptr_sum_d;
   logic [ADDR_WIDTH-1:0] ptr_adv_d, ptr_base_d;
   logic                  en_rise, clr, start_d, aw_hs, b_ok, wlast;

   assign full    = (level_q == LVL_FULL);
   assign push    = s_axis_tvalid & ~full;
   assign pop     = wvalid_q & m_axi_wready;
   assign en_rise = enable & ~enable_q;
   assign clr     = en_rise & (state_q == IDLE);
   assign start_d = enable & (level_q >= LVL_BURST) & (outst_q < OUT_MAX);
   assign aw_hs   = awvalid_q & m_axi_awready;
   assign b_ok    = m_axi_bvalid & (outst_q != 4'd0);
   assign wlast   = wvalid_q & (beat_q == BEAT_LAST);

   // Ring pointer advance with wrap, computed one bit wider to catch carry-out
   always_comb begin
      ptr_sum_d  = {1'b0, wr_ptr_q} + BYTES;
      ptr_adv_d  = ptr_sum_d[ADDR_WIDTH-1:0];
      if (ptr_sum_d >= {1'b0, size_q}) ptr_adv_d = '0;
      ptr_base_d = en_rise ? '0 : wr_ptr_q;
   end

   // FIFO storage; no reset needed since pointers define validity
   always_ff @(posedge aclk) begin
      if (push) mem_q[wa_q] <= s_axis_tdata;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wa_q    <= '0;
         ra_q    <= '0;
         level_q <= '0;
      end else begin
         if (push) wa_q <= wa_q + 1'b1;
         if (pop)  ra_q <= ra_q + 1'b1;
         unique case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Burst FSM: one AW then exactly BURST_LEN W beats, ring pointer moves on wlast
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         awaddr_q  <= '0;
         size_q    <= '0;
         wr_ptr_q  <= '0;
         beat_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (en_rise) wr_ptr_q <= '0;
               if (start_d) begin
                  state_q   <= ADDR;
                  awvalid_q <= 1'b1;
                  awaddr_q  <= cfg_base + ptr_base_d;
                  size_q    <= cfg_size;
               end
            end
            ADDR: begin
               beat_q <= '0;
               if (m_axi_awready) begin
                  state_q   <= DATA;
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b1;
               end
            end
            DATA: begin
               if (m_axi_wready) begin
                  beat_q <= beat_q + 1'b1;
                  if (wlast) begin
                     state_q  <= IDLE;
                     wvalid_q <= 1'b0;
                     wr_ptr_q <= ptr_adv_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Outstanding-response tracking and sticky status, cleared on enable rising from IDLE
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         enable_q <= 1'b0;
         outst_q  <= '0;
         bursts_q <= '0;
         drop_q   <= '0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         enable_q <= enable;
         unique case ({aw_hs, b_ok})
            2'b10:   outst_q <= outst_q + 1'b1;
            2'b01:   outst_q <= outst_q - 1'b1;
            default: outst_q <= outst_q;
         endcase
         if (clr) begin
            bursts_q <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
         end else begin
            if (m_axi_bvalid) bursts_q <= bursts_q + 1'b1;
            if (m_axi_bvalid && m_axi_bresp != 2'b00) err_q <= 1'b1;
            if (s_axis_tvalid && full) begin
               ovf_q  <= 1'b1;
               drop_q <= drop_q + 1'b1;
            end
         end
      end
   end

`ifdef S2MM_DROP_ON_FULL_EN
   assign s_axis_tready = 1'b1;
   assign drop_count    = drop_q;
`else
   assign s_axis_tready = ~full;
   logic unused_drop;
   assign unused_drop   = ^drop_q;
`endif

   assign wr_ptr        = wr_ptr_q;
   assign bursts_done   = bursts_q;
   assign resp_err      = err_q;
   assign overflow      = ovf_q;
   assign m_axi_awid    = '1;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awlen   = 8'(BURST_LEN - 1);
   assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
   assign m_axi_awburst = 2'b01;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = mem_q[ra_q];
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = wlast;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = 1'b1;

endmodule
